// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op codes, scheduler states and op decode helpers
package mdu_pkg;

  localparam int MUL_LAT_DEFAULT  = 2;
  localparam int DIV_ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_acc(input mdu_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_sub(input mdu_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_scheduler_div_iter.sv
// rtl/mdu_scheduler_div_iter.sv - restoring radix-2 divider core, one quotient bit per cycle
// Ports:
//   clk, resetn        clock, async active-low reset
//   start              load operands and begin ITER iterations
//   signed_op          treat a/b as two's complement (magnitudes are divided)
//   a, b               dividend, divisor (b must be non-zero)
//   kill               abandon the division and clear counter/remainder
//   busy               iterations in progress
//   done               high in the last iteration cycle; quot/rem valid then
//   quot, rem          sign-corrected quotient and remainder
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int ITER = DIV_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quot_nx;

  assign w_abs_a = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign w_abs_b = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // Dividend bits shift out of r_quot into the partial remainder while
  // quotient bits shift in from the bottom.
  always_comb begin
    w_rem_sh = {r_rem, r_quot[31]};
    w_diff   = w_rem_sh - {1'b0, r_div};
    if (!w_diff[32]) begin
      w_rem_nx  = w_diff[31:0];
      w_quot_nx = {r_quot[30:0], 1'b1};
    end else begin
      w_rem_nx  = w_rem_sh[31:0];
      w_quot_nx = {r_quot[30:0], 1'b0};
    end
  end

  assign busy = (r_cnt != 6'd0);
  assign done = (r_cnt == 6'd1);

  // Results come from the final step combinationally so the scheduler can
  // capture them in the same cycle the last bit is produced.
  assign quot = r_neg_q ? (~w_quot_nx + 32'd1) : w_quot_nx;
  assign rem  = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quot  <= 32'd0;
      r_div   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (kill) begin
      r_cnt <= 6'd0;
      r_rem <= 32'd0;
    end else if (start) begin
      r_cnt   <= 6'(ITER);
      r_rem   <= 32'd0;
      r_quot  <= w_abs_a;
      r_div   <= w_abs_b;
      r_neg_q <= signed_op && (a[31] ^ b[31]);
      r_neg_r <= signed_op && a[31];
    end else if (busy) begin
      r_cnt  <= r_cnt - 6'd1;
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
    end
  end

endmodule

// File: rtl/mdu_scheduler.sv
// rtl/mdu_scheduler.sv - EXE-stage multiply/divide sequencer with stall, finish and HI/LO result
// Ports:
//   clk, resetn          clock, async active-low reset
//   op_valid, op_code    MDU op held in EXE (stable while stall=1)
//   src_a, src_b         forwarded rs/rt operands
//   hi_in, lo_in         current HI/LO for MADD/MSUB accumulation
//   ex_adv               EXE register loads a new instruction this cycle
//   flush                EXE flush, overrides everything
//   stall                hold the pipeline while an op is in flight
//   finish, res_hi/lo    result valid for the HILO write
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEFAULT,
  parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        ex_adv,
  input  logic        flush,
  output logic        stall,
  output logic        finish,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  mdu_state_t  r_state;
  mdu_state_t  w_next;
  mdu_op_t     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi_acc;
  logic [31:0] r_lo_acc;
  logic [2:0]  r_mul_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;

  mdu_op_t     w_op;
  logic        w_accept;
  logic        w_stall;
  logic        w_finish;
  logic        w_load_mul;
  logic        w_load_dz;
  logic        w_load_div;
  logic        w_div_start;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_quot;
  logic [31:0] w_div_rem;

  mdu_op_t     w_m_op;
  logic [31:0] w_m_a;
  logic [31:0] w_m_b;
  logic [63:0] w_m_acc;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [63:0] w_mul_res;

  assign w_op        = mdu_op_t'(op_code);
  assign w_accept    = (r_state == ST_IDLE) && op_valid && !flush;
  assign w_div_start = w_accept && op_is_div(w_op) && (src_b != 32'd0);

  // Multiply path reads the live inputs in IDLE so MUL_LAT=1 can finish
  // straight from the accept cycle; otherwise it uses the latched copies.
  assign w_m_op  = (r_state == ST_IDLE) ? w_op : r_op;
  assign w_m_a   = (r_state == ST_IDLE) ? src_a : r_a;
  assign w_m_b   = (r_state == ST_IDLE) ? src_b : r_b;
  assign w_m_acc = (r_state == ST_IDLE) ? {hi_in, lo_in} : {r_hi_acc, r_lo_acc};

  // Sign/zero extension to 64 bits makes the low 64 product bits correct
  // for both signed and unsigned operands.
  assign w_ext_a = op_is_signed(w_m_op) ? {{32{w_m_a[31]}}, w_m_a} : {32'd0, w_m_a};
  assign w_ext_b = op_is_signed(w_m_op) ? {{32{w_m_b[31]}}, w_m_b} : {32'd0, w_m_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_mul_res = w_prod;
    if (op_is_acc(w_m_op)) begin
      w_mul_res = op_is_sub(w_m_op) ? (w_m_acc - w_prod) : (w_m_acc + w_prod);
    end
  end

  mdu_div_iter #(
    .ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (w_div_start),
    .signed_op (op_is_signed(w_op)),
    .a         (src_a),
    .b         (src_b),
    .kill      (flush),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quot      (w_div_quot),
    .rem       (w_div_rem)
  );

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_finish   = 1'b0;
    w_load_mul = 1'b0;
    w_load_dz  = 1'b0;
    w_load_div = 1'b0;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            w_stall = 1'b1;
            if (op_is_div(w_op)) begin
              if (src_b == 32'd0) begin
                w_next    = ST_DONE;
                w_load_dz = 1'b1;
              end else begin
                w_next = ST_DIV;
              end
            end else if (MUL_LAT == 1) begin
              w_next     = ST_DONE;
              w_load_mul = 1'b1;
            end else begin
              w_next = ST_MUL;
            end
          end
        end
        ST_MUL: begin
          w_stall = 1'b1;
          if (r_mul_cnt == 3'(MUL_LAT - 1)) begin
            w_next     = ST_DONE;
            w_load_mul = 1'b1;
          end
        end
        ST_DIV: begin
          w_stall = w_div_busy;
          if (w_div_done) begin
            w_next     = ST_DONE;
            w_load_div = 1'b1;
          end
        end
        ST_DONE: begin
          w_finish = 1'b1;
          if (ex_adv) begin
            w_next = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MULT;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_hi_acc  <= 32'd0;
      r_lo_acc  <= 32'd0;
      r_mul_cnt <= 3'd0;
      r_res_hi  <= 32'd0;
      r_res_lo  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= w_op;
        r_a      <= src_a;
        r_b      <= src_b;
        r_hi_acc <= hi_in;
        r_lo_acc <= lo_in;
      end
      if (flush) begin
        r_mul_cnt <= 3'd0;
      end else if (w_accept) begin
        r_mul_cnt <= 3'd1;
      end else if (r_state == ST_MUL) begin
        r_mul_cnt <= r_mul_cnt + 3'd1;
      end
      if (w_load_mul) begin
        r_res_hi <= w_mul_res[63:32];
        r_res_lo <= w_mul_res[31:0];
      end else if (w_load_dz) begin
        r_res_hi <= src_a;
        r_res_lo <= 32'hFFFF_FFFF;
      end else if (w_load_div) begin
        r_res_hi <= w_div_rem;
        r_res_lo <= w_div_quot;
      end
    end
  end

  assign stall  = resetn && w_stall;
  assign finish = w_finish;
  assign res_hi = r_res_hi;
  assign res_lo = r_res_lo;

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb/tb_mdu_scheduler.sv - scoreboard bench for mdu_scheduler
module tb_mdu_scheduler;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b, hi_in, lo_in;
  logic        ex_adv, flush;
  logic        stall, finish;
  logic [31:0] res_hi, res_lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       nm;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  logic prev_fin = 1'b0;

  mdu_scheduler #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .ex_adv   (ex_adv),
    .flush    (flush),
    .stall    (stall),
    .finish   (finish),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rising finish pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (finish && !prev_fin) begin
      if (sb.size() == 0) begin
        check("unexpected_finish", 64'(finish), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.nm, "_hi"}, 64'(res_hi), 64'(e.hi));
        check({e.nm, "_lo"}, 64'(res_lo), 64'(e.lo));
        check({e.nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
    prev_fin <= finish;
  end

  always @(negedge clk) begin
    assert (!(resetn && stall && !op_valid))
      else $error("op_valid dropped while op in flight");
  end

  task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int n_hold, input string nm);
    int  n_stall = 0;
    bit  seen = 0;
    exp_t e;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b; hi_in = h; lo_in = l; ex_adv = 1'b0;
    e.nm = nm; e.cyc = cyc + lat; e.hi = eh; e.lo = el;
    sb.push_back(e);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (finish) seen = 1;
      else if (stall) n_stall++;
    end
    check({nm, "_finish_seen"}, 64'(seen), 64'd1);
    check({nm, "_stall_cycles"}, 64'(n_stall), 64'(lat));
    for (int i = 0; i < n_hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, "_hold_finish"}, 64'(finish), 64'd1);
      check({nm, "_hold_stall"}, 64'(stall), 64'd0);
      check({nm, "_hold_res"}, {res_hi, res_lo}, {eh, el});
    end
    @(posedge clk); #1; ex_adv = 1'b1;
    @(posedge clk); #1; ex_adv = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check({nm, "_idle_finish"}, 64'(finish), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b1; op_code = 3'd0; src_a = 32'd5; src_b = 32'd5;
    hi_in = 32'd0; lo_in = 32'd0; ex_adv = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_res", {res_hi, res_lo}, 64'd0);
    op_valid = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        0, 0,            32'hFFFF_FFFF, 32'hFFFF_FFEB, 2,  0, "mult_neg");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,           32'hFFFF_FFFE, 32'h0000_0001, 2,  3, "multu_max_hold");
    run_op(OP_DIVU,  32'd100,       32'd7,        0, 0,            32'd2,         32'd14,        33, 0, "divu_100_7");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, 0,            32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0,           32'd0,         32'h8000_0000, 33, 0, "div_min_m1");
    run_op(OP_DIVU,  32'h1234_5678, 32'd0,        0, 0,            32'h1234_5678, 32'hFFFF_FFFF, 1,  0, "divu_by0");
    run_op(OP_DIV,   32'h8000_0000, 32'd0,        0, 0,            32'h8000_0000, 32'hFFFF_FFFF, 1,  0, "div_by0");
    run_op(OP_MADDU, 32'd1,         32'd1,        0, 32'hFFFF_FFFF, 32'd1,        32'd0,         2,  0, "maddu_carry");
    run_op(OP_MSUB,  32'd1,         32'd1,        0, 0,            32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  0, "msub_borrow");
    run_op(OP_MADD,  32'hFFFF_FFFF, 32'd2,        0, 32'd5,        32'd0,         32'd3,         2,  0, "madd_neg");

    // Flush a divide at cycle 10, then re-issue it.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(stall), 64'd0);
    check("flush_finish", 64'(finish), 64'd0);
    @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("post_flush_stall", 64'(stall), 64'd0);
    check("post_flush_finish", 64'(finish), 64'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 0, 0, 32'd0, 32'd3, 33, 0, "divu_reissue");

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    check("mid_div_stall", 64'(stall), 64'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_stall", 64'(stall), 64'd0);
    check("async_rst_finish", 64'(finish), 64'd0);
    check("async_rst_res", {res_hi, res_lo}, 64'd0);
    op_valid = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    run_op(OP_MULT, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, 2, 0, "mult_after_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Sequences the multi-cycle multiply/divide resource in the EXE stage.
- Accepts one MDU op from the EXE register and runs it on a pipelined multiplier or an iterative radix-2 divider.
- Drives the EXE stall while the op is in flight, then holds a HI/LO result with a finish flag until the EXE stage advances.
- Performs MADD/MSUB accumulation against the HILO values sampled at accept, and cancels cleanly on pipeline flush.

Parameters:
- MUL_LAT, 2, cycles from the accept cycle to the first finish cycle for multiply-class ops (legal range 1..4).
- DIV_ITER, 32, divider iterations (one quotient bit per cycle); fixed at 32 for MIPS32.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset
- op_valid  in  1  EXE holds an MDU op; held stable while stall=1
- op_code  in  3  MduOp: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
- src_a  in  32  forwarded rs operand
- src_b  in  32  forwarded rt operand
- hi_in  in  32  current HI, used by MADD/MSUB
- lo_in  in  32  current LO, used by MADD/MSUB
- ex_adv  in  1  EXE register loads a new instruction this cycle (EXE_Wr)
- flush  in  1  EXE flush (exception or redirect)
- stall  out  1  hold the pipeline
- finish  out  1  res_hi/res_lo valid for HILO write
- res_hi  out  32  HI result
- res_lo  out  32  LO result

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: state=IDLE, res_hi=0, res_lo=0, finish=0, all counters 0. stall is forced to 0 while resetn=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept when op_valid=1 and flush=0 (accept cycle = cycle 0).
  - At accept, latch src_a, src_b, op_code, hi_in, lo_in.
  - stall=1 combinationally in the accept cycle.
  - Next state is MUL for multiply-class ops and DIV for divide ops.
  - DIV/DIVU with src_b=0 goes directly to DONE.
- MUL:
  - stall=1. Product is computed over MUL_LAT-1 cycles in MUL.
  - The first finish cycle is cycle MUL_LAT.
  - Signed product for MULT/MADD/MSUB; unsigned product for the U variants.
  - MADD: {res_hi,res_lo} = {hi_in,lo_in} + product, mod 2^64.
  - MSUB: {res_hi,res_lo} = {hi_in,lo_in} - product, mod 2^64.
- DIV:
  - stall=1. Restoring division on |a| and |b| (signed ops) or raw a and b (unsigned ops), one bit per cycle for DIV_ITER cycles.
  - The first finish cycle is cycle DIV_ITER+1 (33).
  - Sign fixup: quotient is negated if sign(a)^sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero:
  - DONE is reached at cycle 1.
  - res_lo=0xFFFFFFFF, res_hi=src_a, for both DIV and DIVU.
- DONE:
  - stall=0 and finish=1; res_hi/res_lo are held constant.
  - If ex_adv=1, next state is IDLE. Otherwise stay in DONE.
  - The op is never re-issued, even though op_valid stays high.
  - finish may be high for several cycles. HILO writes are idempotent because the accumulate result was computed once from the latched hi_in/lo_in.
- Flush (highest priority, any state):
  - stall=0 and finish=0 in the same cycle; next state is IDLE.
  - Divider counter/remainder and the multiplier valid pipe are cleared.
  - res_hi/res_lo keep their old values; they are don't-care while finish=0.
- flush together with an accept in IDLE: no accept.
- ex_adv in DONE together with a new op_valid: go to IDLE. The new op is accepted on the next cycle (one bubble cycle; this is intended).
- op_valid dropping mid-op without flush is illegal; a bench assertion flags it.
- Asserting resetn mid-operation returns the block to the reset values immediately.

Decomposition:
- Package mdu_pkg:
  - MduOp typedef enum logic [2:0].
  - MduState typedef enum.
  - Helpers op_is_div, op_is_signed, op_is_acc.
  - DIV_ITER default.
- One sub-module, mdu_div_iter: restoring divider core.
  - Inputs: start, signed_op, a, b, kill.
  - Outputs: busy, done (1-cycle pulse), quot, rem.
  - Uses a 6-bit iteration counter.
- The multiplier pipe and the accumulate stage stay inline in mdu_scheduler.

Test Plan:
- MULT a=0xFFFFFFFD, b=7 (MUL_LAT=2) -> stall high in cycles 0-1; finish at cycle 2 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> stall cycles 0..32; finish at cycle 33 with lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU b=0 -> finish at cycle 1, lo=0xFFFFFFFF, hi=a.
- MADDU hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0.
- MSUB hi_in=0, lo_in=0, a=1, b=1 -> hi=lo=0xFFFFFFFF.
- DIVU 9/3 with flush at cycle 10 -> cycle 10 stall=0; cycle 11 IDLE; finish never asserted. Re-issue DIVU 9/3 -> lo=3, hi=0 at cycle 33, with no stale remainder.
- Hold ex_adv=0 for 3 cycles in DONE with op_valid=1 -> finish stays 1 and results stay stable, with no re-accept. ex_adv=1 -> IDLE next cycle.
- Assert resetn=0 mid-DIV -> outputs go to 0 immediately without waiting for a clock edge. After release, a MULT 2*3 gives lo=6, hi=0.
